lii_out_packer: RTL

LII_OUT_PACKER -- requirements
Module: lii_out_packer

---
 rtl/lii_out_packer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lii_out_packer.sv
// lii_out_packer: gathers DW-bit kernel words into PW-bit LII phy beats.
// Words fill lanes from lane 0 upward; a beat is handed to the output
// register when it is full, closes a packet, or has sat idle too long.
module lii_out_packer #(
  parameter int         PW           = 64,
  parameter int         DW           = 32,
  parameter logic [7:0] SRC_ID       = 8'h00,
  parameter logic [7:0] DST_ID       = 8'h01,
  parameter int         FLUSH_CYCLES = 16
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [DW-1:0]     k_stream_tdata,
  input  logic              k_stream_tvalid,
  output logic              k_stream_tready,
  input  logic              k_stream_tlast,
  output logic [PW-1:0]     lii_out_p0_tdata,
  output logic              lii_out_p0_tvalid,
  input  logic              lii_out_p0_tready,
  output logic [PW/DW-1:0]  lii_out_p0_tkeep,
  output logic              lii_out_p0_tlast,
  output logic [7:0]        lii_out_p0_src,
  output logic [7:0]        lii_out_p0_dst,
  output logic              ce
);

  localparam int LANES = PW / DW;
  localparam int CW    = $clog2(LANES + 1);
  localparam int IW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(LANES);
  localparam logic [IW-1:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? IW'(FLUSH_CYCLES - 1) : '0;

  // Reject widths that cannot be split into at least two whole lanes
  generate
    if ((PW % DW) != 0 || LANES < 2) begin : g_bad_params
      $error("lii_out_packer: PW must be a multiple of DW with PW/DW >= 2");
    end
  endgenerate

  logic [PW-1:0]    acc_data;
  logic [CW-1:0]    acc_cnt;
  logic             acc_last;
  logic [IW-1:0]    idle_cnt;

  logic [PW-1:0]    out_data;
  logic [LANES-1:0] out_keep;
  logic             out_last;
  logic             out_valid;

  logic             accept;
  logic             partial;
  logic             flush_fire;
  logic             pending;
  logic             move;
  logic [PW-1:0]    acc_data_nxt;
  logic [CW-1:0]    acc_cnt_nxt;
  logic             acc_last_nxt;
  logic [IW-1:0]    idle_cnt_nxt;
  logic [LANES-1:0] keep_nxt;
  logic [PW-1:0]    base_data;
  logic [CW-1:0]    base_cnt;
  logic             base_last;

  // Handshake decisions plus next accumulator/idle state; a move empties the
  // accumulator first so a word accepted alongside it lands in lane 0
  always_comb begin
    partial      = (acc_cnt != '0) && (acc_cnt != FULL_CNT) && !acc_last;
    flush_fire   = (FLUSH_CYCLES != 0) && partial && (idle_cnt == FLUSH_LAST);
    pending      = (acc_cnt == FULL_CNT) || acc_last || flush_fire;
    move         = pending && (!out_valid || lii_out_p0_tready);
    k_stream_tready = !pending || move;
    accept       = k_stream_tvalid && k_stream_tready;

    base_data    = move ? '0 : acc_data;
    base_cnt     = move ? '0 : acc_cnt;
    base_last    = move ? 1'b0 : acc_last;

    acc_data_nxt = base_data;
    for (int i = 0; i < LANES; i++) begin
      if (accept && (base_cnt == CW'(i))) begin
        acc_data_nxt[i*DW +: DW] = k_stream_tdata;
      end
    end
    acc_cnt_nxt  = base_cnt + CW'(accept);
    acc_last_nxt = base_last | (accept & k_stream_tlast);

    keep_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_nxt[i] = (CW'(i) < acc_cnt);
    end

    idle_cnt_nxt = idle_cnt;
    if (FLUSH_CYCLES == 0 || accept || move) begin
      idle_cnt_nxt = '0;
    end else if (partial && !flush_fire) begin
      idle_cnt_nxt = idle_cnt + 1'b1;
    end
  end

  // Accumulator and idle counter registers
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      acc_data <= '0;
      acc_cnt  <= '0;
      acc_last <= 1'b0;
      idle_cnt <= '0;
    end else begin
      acc_data <= acc_data_nxt;
      acc_cnt  <= acc_cnt_nxt;
      acc_last <= acc_last_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Output beat register: loads on move, otherwise holds until the phy takes it
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (move) begin
      out_data  <= acc_data;
      out_keep  <= keep_nxt;
      out_last  <= acc_last;
      out_valid <= 1'b1;
    end else if (lii_out_p0_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign lii_out_p0_tdata  = out_data;
  assign lii_out_p0_tkeep  = out_keep;
  assign lii_out_p0_tlast  = out_last;
  assign lii_out_p0_tvalid = out_valid;
  assign lii_out_p0_src    = SRC_ID;
  assign lii_out_p0_dst    = DST_ID;
  assign ce                = k_stream_tready;

endmodule
